// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_pick.sv
// Rotating-priority pick: lowest set bit at or above ptr, else lowest set bit overall,
// with one optional index excluded from the candidates.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [IDX_W-1:0]   excl_idx,
  input  logic               excl_en,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] hi;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;
  logic               hi_found;
  logic               lo_found;

  // Candidate masking followed by the two lowest-index encoders.
  always_comb begin
    cand     = req;
    hi       = {NUM_REQ{1'b0}};
    hi_idx   = {IDX_W{1'b0}};
    lo_idx   = {IDX_W{1'b0}};
    hi_found = 1'b0;
    lo_found = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (excl_en && (excl_idx == IDX_W'(i))) begin
        cand[i] = 1'b0;
      end else begin
        cand[i] = req[i];
      end
      if (IDX_W'(i) >= ptr) begin
        hi[i] = cand[i];
      end else begin
        hi[i] = 1'b0;
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && hi[i]) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end else begin
        hi_found = hi_found;
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!lo_found && cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end else begin
        lo_found = lo_found;
      end
    end

    if (hi_found) begin
      pick_idx = hi_idx;
    end else begin
      pick_idx = lo_idx;
    end
    pick_valid = lo_found;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with grant hold and optional hold-timeout preemption.
// All outputs come straight from registers.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               preempt
);

  localparam int               HOLD_W    = idx_width(MAX_HOLD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);
  localparam logic              HOLD_EN  = (MAX_HOLD != 0);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               preempt_q, preempt_d;

  logic [IDX_W-1:0]   ptr_adv;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_oh;
  logic               in_grant;
  logic               cur_req;
  logic               timeout;

  // While granting, the pick excludes the current owner and starts just past it,
  // so the same instance serves idle arbitration, release and preemption.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (pick_ptr),
    .excl_idx   (gnt_idx_q),
    .excl_en    (in_grant),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Pointer advance, pick steering and grant decoding.
  always_comb begin
    in_grant = (state_q == GRANT);
    cur_req  = |(req & gnt_q);
    timeout  = HOLD_EN && (hold_q == HOLD_LAST);
    if (gnt_idx_q == LAST_IDX) begin
      ptr_adv = {IDX_W{1'b0}};
    end else begin
      ptr_adv = gnt_idx_q + IDX_W'(1);
    end
    if (in_grant) begin
      pick_ptr = ptr_adv;
    end else begin
      pick_ptr = ptr_q;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_oh[i] = 1'b1;
      end else begin
        pick_oh[i] = 1'b0;
      end
    end
  end

  // Next-state logic; a release takes precedence over a coincident timeout.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    preempt_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d     = pick_oh;
          gnt_idx_d = pick_idx;
          hold_d    = {HOLD_W{1'b0}};
          state_d   = GRANT;
        end else begin
          gnt_d     = {NUM_REQ{1'b0}};
          gnt_idx_d = {IDX_W{1'b0}};
          state_d   = IDLE;
        end
      end
      GRANT: begin
        if (!cur_req) begin
          ptr_d  = ptr_adv;
          hold_d = {HOLD_W{1'b0}};
          if (pick_valid) begin
            gnt_d     = pick_oh;
            gnt_idx_d = pick_idx;
            state_d   = GRANT;
          end else begin
            gnt_d     = {NUM_REQ{1'b0}};
            gnt_idx_d = {IDX_W{1'b0}};
            state_d   = IDLE;
          end
        end else if (timeout && pick_valid) begin
          ptr_d     = ptr_adv;
          hold_d    = {HOLD_W{1'b0}};
          gnt_d     = pick_oh;
          gnt_idx_d = pick_idx;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d   = IDLE;
        ptr_d     = {IDX_W{1'b0}};
        hold_d    = {HOLD_W{1'b0}};
        gnt_d     = {NUM_REQ{1'b0}};
        gnt_idx_d = {IDX_W{1'b0}};
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      hold_q      <= {HOLD_W{1'b0}};
      gnt_q       <= {NUM_REQ{1'b0}};
      gnt_idx_q   <= {IDX_W{1'b0}};
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: three configurations run side by side against a
// rotation-search reference model, plus directed scenarios with constant expectations.
module tb_rr_priority_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req4, gnt4;
  logic [1:0] idx4;
  logic       v4, p4;
  logic [4:0] req5, gnt5;
  logic [2:0] idx5;
  logic       v5, p5;
  logic [3:0] reqh, gnth;
  logic [1:0] idxh;
  logic       vh, ph;

  rr_priority_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) u_a4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4),
    .gnt_valid(v4), .gnt_idx(idx4), .preempt(p4));

  rr_priority_arbiter #(.NUM_REQ(5), .MAX_HOLD(0)) u_a5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .gnt(gnt5),
    .gnt_valid(v5), .gnt_idx(idx5), .preempt(p5));

  rr_priority_arbiter #(.NUM_REQ(4), .MAX_HOLD(3)) u_ah (
    .clk(clk), .rst_n(rst_n), .req(reqh), .gnt(gnth),
    .gnt_valid(vh), .gnt_idx(idxh), .preempt(ph));

  int checks = 0;
  int errs   = 0;

  // Reference model: owner (-1 when idle), rotation start, cycles held, preempt flag.
  int   nn [3] = '{4, 5, 4};
  int   mh [3] = '{0, 0, 3};
  int   m_owner [3];
  int   m_ptr   [3];
  int   m_held  [3];
  logic m_pre   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_held[d]  = 0;
      m_pre[d]   = 1'b0;
    end
  endtask

  // First requester met when walking n slots from p upward with wrap, skipping excl.
  function automatic int rot_pick(input logic [31:0] r, input int p, input int n, input int excl);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (p + k) % n;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] get_req(input int d);
    case (d)
      0: return 32'(req4);
      1: return 32'(req5);
      2: return 32'(reqh);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input int d);
    logic [31:0] r;
    int n, o, nxt, w;
    r = get_req(d);
    n = nn[d];
    o = m_owner[d];
    m_pre[d] = 1'b0;
    if (o < 0) begin
      m_owner[d] = rot_pick(r, m_ptr[d], n, -1);
      m_held[d]  = 0;
    end else begin
      nxt = (o + 1) % n;
      w   = rot_pick(r, nxt, n, o);
      if (!r[o]) begin
        m_ptr[d]   = nxt;
        m_owner[d] = w;
        m_held[d]  = 0;
      end else if (mh[d] != 0 && m_held[d] == mh[d] - 1 && w >= 0) begin
        m_ptr[d]   = nxt;
        m_owner[d] = w;
        m_held[d]  = 0;
        m_pre[d]   = 1'b1;
      end else if (m_held[d] < mh[d]) begin
        m_held[d]++;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic [31:0] g, ix, eg, eix;
      logic v, p;
      case (d)
        0: begin g = 32'(gnt4); ix = 32'(idx4); v = v4; p = p4; end
        1: begin g = 32'(gnt5); ix = 32'(idx5); v = v5; p = p5; end
        default: begin g = 32'(gnth); ix = 32'(idxh); v = vh; p = ph; end
      endcase
      eg  = (m_owner[d] < 0) ? 32'd0 : (32'd1 << m_owner[d]);
      eix = (m_owner[d] < 0) ? 32'd0 : 32'(m_owner[d]);
      chk($sformatf("d%0d_gnt", d), g, eg);
      chk($sformatf("d%0d_idx", d), ix, eix);
      chk($sformatf("d%0d_valid", d), {31'd0, v}, {31'd0, (m_owner[d] >= 0)});
      chk($sformatf("d%0d_preempt", d), {31'd0, p}, {31'd0, m_pre[d]});
      chk($sformatf("d%0d_onehot0", d), {31'd0, $onehot0(g)}, 32'd1);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic cycle();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) model_step(d);
    end
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int e;
    rst_n = 1'b0;
    req4  = 4'd0;
    req5  = 5'd0;
    reqh  = 4'd0;
    model_reset();
    @(negedge clk);
    check_all();
    cycle();
    rst_n = 1'b1;

    // Grant from a two-bit request, then hand-over with no idle cycle.
    req4 = 4'b0110;
    cycle();
    chk("t1_gnt", 32'(gnt4), 32'h2);
    chk("t1_idx", 32'(idx4), 32'd1);
    req4 = 4'b0100;
    cycle();
    chk("t1_nobubble", 32'(gnt4), 32'h4);

    // Fair rotation with everyone requesting.
    do_reset();
    req4 = 4'hF;
    cycle();
    chk("t2_first", 32'(idx4), 32'd0);
    e = 0;
    for (int k = 0; k < 4; k++) begin
      req4 = 4'hF & ~(4'b0001 << e);
      cycle();
      e = (e + 1) % 4;
      chk($sformatf("t2_next%0d", k), 32'(idx4), 32'(e));
      cycle();
      req4 = 4'hF;
      cycle();
      chk($sformatf("t2_hold%0d", k), 32'(idx4), 32'(e));
    end

    // Pointer wrap for a non-power-of-two width.
    req4 = 4'd0;
    do_reset();
    req5 = 5'b10000;
    cycle();
    chk("t3_top", 32'(gnt5), 32'h10);
    req5 = 5'b00011;
    cycle();
    chk("t3_wrap", 32'(gnt5), 32'h01);

    // Hold timeout and preemption.
    req5 = 5'd0;
    do_reset();
    reqh = 4'b0011;
    cycle();
    chk("t4_g0", 32'(gnth), 32'h1);
    cycle();
    cycle();
    chk("t4_g0_held", 32'(gnth), 32'h1);
    chk("t4_nopre", {31'd0, ph}, 32'd0);
    cycle();
    chk("t4_pre_gnt", 32'(gnth), 32'h2);
    chk("t4_pre_pulse", {31'd0, ph}, 32'd1);
    cycle();
    chk("t4_pre_clear", {31'd0, ph}, 32'd0);
    cycle();
    cycle();
    chk("t4_back_gnt", 32'(gnth), 32'h1);
    chk("t4_back_pulse", {31'd0, ph}, 32'd1);
    reqh = 4'b0001;
    repeat (10) cycle();
    chk("t4_alone_gnt", 32'(gnth), 32'h1);
    chk("t4_alone_pre", {31'd0, ph}, 32'd0);

    // Release coinciding with timeout is a plain release.
    do_reset();
    reqh = 4'b0011;
    repeat (3) cycle();
    reqh = 4'b0010;
    cycle();
    chk("t4_rel_gnt", 32'(gnth), 32'h2);
    chk("t4_rel_pre", {31'd0, ph}, 32'd0);

    // Asynchronous reset between edges while granting.
    reqh = 4'd0;
    req4 = 4'b0001;
    cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt4), 32'h0);
    chk("t5_async_valid", {31'd0, v4}, 32'd0);
    model_reset();
    @(negedge clk);
    cycle();
    req4  = 4'b1000;
    rst_n = 1'b1;
    cycle();
    chk("t5_after", 32'(gnt4), 32'h8);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req4 = req4 ^ 4'($urandom() & $urandom() & $urandom());
      req5 = req5 ^ 5'($urandom() & $urandom() & $urandom());
      reqh = reqh ^ 4'($urandom() & $urandom());
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
